// File: rtl/button_pkg.sv
// Shared FSM encoding and default timing for the push-button conditioner (50 MHz board clock).
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;  // 20 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000; // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;  // 100 ms
    localparam int unsigned DEF_CNT_W           = 26;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer plus stable-time filter; emits a debounced level and
// registered one-cycle rise/fall strobes aligned with the level change.
module debounce_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] timer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            timer <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= button_raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 != level) begin
                if (timer == DB_LAST) begin
                    level <= sync2;
                    rise  <= sync2;
                    fall  <= ~sync2;
                    timer <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: debounced level, press/release pulses, optional
// hold-to-repeat, and a registered count event for the press counter.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_raw,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic count_pulse
);

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             filt_level;
    logic             filt_rise;
    logic             filt_fall;
    btn_state_t       state;
    logic [CNT_W-1:0] hold_timer;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_filter (
        .clk       (clk),
        .reset_n   (reset_n),
        .button_raw(button_raw),
        .level     (filt_level),
        .rise      (filt_rise),
        .fall      (filt_fall)
    );

    // Release is tested before timer expiry so a coincident fall suppresses the repeat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            hold_timer    <= '0;
            button_level  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            count_pulse   <= 1'b0;
        end else begin
            button_level  <= filt_level;
            count_pulse   <= press_pulse | repeat_pulse;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    hold_timer <= '0;
                    if (filt_rise) begin
                        state       <= HELD;
                        press_pulse <= 1'b1;
                    end
                end
                HELD: begin
                    if (filt_fall) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        hold_timer    <= '0;
                    end else if (REPEAT_EN) begin
                        if (hold_timer == DLY_LAST) begin
                            state        <= REPEAT;
                            repeat_pulse <= 1'b1;
                            hold_timer   <= '0;
                        end else begin
                            hold_timer <= hold_timer + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (filt_fall) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        hold_timer    <= '0;
                    end else if (hold_timer == PER_LAST) begin
                        repeat_pulse <= 1'b1;
                        hold_timer   <= '0;
                    end else begin
                        hold_timer <= hold_timer + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    hold_timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing (debounce 4, delay 10, period 5).
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic button_raw = 1'b0;

    logic lvl0, prs0, rel0, rep0, cnt0;
    logic lvl1, prs1, rel1, rep1, cnt1;
    logic [4:0] out0, out1;

    assign out0 = {lvl0, prs0, rel0, rep0, cnt0};
    assign out1 = {lvl1, prs1, rel1, rep1, cnt1};

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .CNT_W(8)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .button_raw(button_raw),
        .button_level(lvl0), .press_pulse(prs0), .release_pulse(rel0),
        .repeat_pulse(rep0), .count_pulse(cnt0)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .CNT_W(8)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .button_raw(button_raw),
        .button_level(lvl1), .press_pulse(prs1), .release_pulse(rel1),
        .repeat_pulse(rep1), .count_pulse(cnt1)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passed = 0;

    typedef struct {
        logic       raw;
        logic [4:0] exp;   // {level, press, release, repeat, count}
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    // Called at a falling edge: drive raw, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic r);
        button_raw = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        button_raw = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [4:0] mk(input bit l, input bit p, input bit rl, input bit rp, input bit c);
        return {l, p, rl, rp, c};
    endfunction

    int cnt_total;
    int rep_total;

    initial begin
        // Clean press then release: press at edge 6, repeat at 16, release at 18 (raw low from edge 12).
        for (int i = 0; i < 22; i++) begin
            tbl[i].raw = (i < 12);
            tbl[i].exp = mk(i >= 6 && i < 18, i == 6, i == 18, i == 16, i == 7 || i == 17);
        end

        do_reset();
        check("reset_state", 0, {27'd0, out0}, 32'd0);
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].raw);
            check("clean_press", i, {27'd0, out0}, {27'd0, tbl[i].exp});
        end

        // Asynchronous reset in the middle of a held press, raw stays high across it.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1);
        check("held_before_reset", 0, {31'd0, lvl0}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check("async_reset", 0, {27'd0, out0}, 32'd0);
        @(negedge clk);
        check("in_reset", 0, {27'd0, out0}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            check("after_reset", i, {27'd0, out0}, {27'd0, mk(i >= 6, i == 6, 1'b0, 1'b0, i == 7)});
        end

        // Bounce: 1,1,1,0 then held high -> single press at edge 10.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(i != 3);
            check("bounce", i, {27'd0, out0}, {27'd0, mk(i >= 10, i == 10, 1'b0, 1'b0, i == 11)});
        end

        // Glitch of DEBOUNCE_CYCLES-1 cycles is rejected.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(i < 3);
            check("glitch", i, {27'd0, out0}, 32'd0);
        end

        // Hold: raw high edges 0..29. Repeats at 16,21,26,31; release at 36 coincides with the
        // next repeat expiry and must win. The repeat-disabled instance sees the same stimulus.
        do_reset();
        cnt_total = 0;
        rep_total = 0;
        for (int i = 0; i < 46; i++) begin
            step(i < 30);
            if (cnt0) cnt_total++;
            if (rep1) rep_total++;
            check("hold_repeat", i, {27'd0, out0},
                  {27'd0, mk(i >= 6 && i < 36, i == 6, i == 36,
                             i == 16 || i == 21 || i == 26 || i == 31,
                             i == 7 || i == 17 || i == 22 || i == 27 || i == 32)});
            check("no_repeat", i, {27'd0, out1},
                  {27'd0, mk(i >= 6 && i < 36, i == 6, i == 36, 1'b0, i == 7)});
        end
        check("count_total", 0, cnt_total, 32'd5);
        check("repeat_off_total", 0, rep_total, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
